// File: rtl/screen_scanner_pkg.sv
// Shared screen geometry, scanner state encoding and request word layout.
package screen_scanner_pkg;

  localparam int SCREEN_W    = 320;
  localparam int SCREEN_H    = 240;
  localparam int PIX_LATENCY = 2;
  localparam int XW          = 9;
  localparam int YW          = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } scan_state_t;

  typedef struct packed {
    logic          vld;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } pix_req_t;

endpackage

// File: rtl/scan_delay.sv
// Delays a pixel request word by DEPTH cycles (DEPTH=0 is a wire).
// No backpressure; reset clears every stage so nothing emerges afterwards.
module scan_delay
  import screen_scanner_pkg::*;
#(
  parameter int DEPTH = PIX_LATENCY
) (
  input  logic     Clock,
  input  logic     Reset,
  input  pix_req_t din,
  output pix_req_t dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign dout = din;
    end else begin : g_pipe
      pix_req_t pipe [DEPTH];

      always_ff @(posedge Clock) begin
        if (Reset) begin
          for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= din;
          for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
      end

      assign dout = pipe[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/screen_scanner.sv
// Raster-scans a pixel responder and replays its answers as framebuffer plots.
// Plot trails the request by LATENCY cycles; no backpressure, one pixel per cycle.
module screen_scanner
  import screen_scanner_pkg::*;
#(
  parameter int         WIDTH   = SCREEN_W,
  parameter int         HEIGHT  = SCREEN_H,
  parameter int         LATENCY = PIX_LATENCY,
  parameter logic [2:0] FG      = 3'b111,
  parameter logic [2:0] BG      = 3'b000
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Continuous,
  output logic [XW-1:0] VGAx,
  output logic [YW-1:0] VGAy,
  input  logic          VGAcol,
  output logic [XW-1:0] PlotX,
  output logic [YW-1:0] PlotY,
  output logic [2:0]    PlotCol,
  output logic          Plot,
  output logic          Busy,
  output logic          FrameDone,
  output logic [7:0]    FrameCount
);

  localparam int            DW         = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [XW-1:0] X_LAST     = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST     = YW'(HEIGHT - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(LATENCY - 1);

  scan_state_t   state, state_nxt;
  logic [XW-1:0] x_cnt;
  logic [YW-1:0] y_cnt;
  logic [DW-1:0] drain_cnt;
  logic [7:0]    frame_cnt;
  logic          last_px;
  pix_req_t      req, emerge;

  assign last_px = (x_cnt == X_LAST) && (y_cnt == Y_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start) state_nxt = SCAN;
      SCAN:    if (last_px) state_nxt = (LATENCY == 0) ? DONE : DRAIN;
      DRAIN:   if (drain_cnt == DRAIN_LAST) state_nxt = DONE;
      DONE:    state_nxt = Continuous ? SCAN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Counters wrap back to 0 on the last pixel, so they rest at 0 outside SCAN.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= IDLE;
      x_cnt     <= '0;
      y_cnt     <= '0;
      drain_cnt <= '0;
      frame_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
      if (state == SCAN) begin
        if (x_cnt == X_LAST) begin
          x_cnt <= '0;
          y_cnt <= (y_cnt == Y_LAST) ? '0 : y_cnt + 1'b1;
        end else begin
          x_cnt <= x_cnt + 1'b1;
        end
      end
      if (state == DONE) frame_cnt <= frame_cnt + 1'b1;
    end
  end

  assign req.vld = (state == SCAN);
  assign req.x   = x_cnt;
  assign req.y   = y_cnt;

  scan_delay #(.DEPTH(LATENCY)) u_delay (
    .Clock (Clock),
    .Reset (Reset),
    .din   (req),
    .dout  (emerge)
  );

  assign VGAx       = x_cnt;
  assign VGAy       = y_cnt;
  assign Plot       = emerge.vld;
  assign PlotX      = emerge.x;
  assign PlotY      = emerge.y;
  assign PlotCol    = !emerge.vld ? 3'b000 : (VGAcol ? FG : BG);
  assign Busy       = (state == SCAN) || (state == DRAIN);
  assign FrameDone  = (state == DONE);
  assign FrameCount = frame_cnt;

endmodule

// File: tb/tb_screen_scanner.sv
// Scoreboard bench for screen_scanner on a small 8x4 screen with a 2-cycle parity responder.
module tb_screen_scanner;

  localparam int TW = 8;
  localparam int TH = 4;
  localparam int TL = 2;
  localparam int FRAME_CYC = TW * TH + TL + 1;

  logic       Clock = 1'b0;
  logic       Reset, Start, Continuous, VGAcol;
  logic [8:0] VGAx, PlotX;
  logic [7:0] VGAy, PlotY;
  logic [2:0] PlotCol;
  logic       Plot, Busy, FrameDone;
  logic [7:0] FrameCount;

  screen_scanner #(
    .WIDTH(TW), .HEIGHT(TH), .LATENCY(TL), .FG(3'b111), .BG(3'b000)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Continuous(Continuous),
    .VGAx(VGAx), .VGAy(VGAy), .VGAcol(VGAcol),
    .PlotX(PlotX), .PlotY(PlotY), .PlotCol(PlotCol), .Plot(Plot),
    .Busy(Busy), .FrameDone(FrameDone), .FrameCount(FrameCount)
  );

  always #5 Clock = ~Clock;

  // Responder: parity of the requested coordinate, two cycles later.
  logic rsp_d1 = 1'b0, rsp_d2 = 1'b0;
  always @(posedge Clock) begin
    rsp_d1 <= VGAx[0] ^ VGAy[0];
    rsp_d2 <= rsp_d1;
  end
  assign VGAcol = rsp_d2;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  logic [19:0] exp_q[$];
  int          done_cyc[$];
  logic [19:0] e;
  int cyc = 0;
  int first_plot, last_plot, max_gap, plot_cnt, busy_rise, busy_len, done_cnt = 0;
  bit busy_prev = 1'b0;

  always @(posedge Clock) cyc <= cyc + 1;

  always @(negedge Clock) begin
    if (Plot === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("plot_extra", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("plot_pix", {12'd0, PlotX, PlotY, PlotCol}, {12'd0, e});
      end
      if (first_plot < 0) first_plot = cyc;
      if (last_plot >= 0 && cyc - last_plot - 1 > max_gap) max_gap = cyc - last_plot - 1;
      last_plot = cyc;
      plot_cnt++;
    end
    if (Busy === 1'b1 && !busy_prev) busy_rise = cyc;
    if (Busy === 1'b1) busy_len++;
    busy_prev = (Busy === 1'b1);
    if (FrameDone === 1'b1) begin
      done_cnt++;
      done_cyc.push_back(cyc);
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clock);
      #1;
    end
  endtask

  task automatic push_frames(input int n);
    for (int f = 0; f < n; f++)
      for (int y = 0; y < TH; y++)
        for (int x = 0; x < TW; x++)
          exp_q.push_back({9'(x), 8'(y), (((x ^ y) & 1) != 0) ? 3'b111 : 3'b000});
  endtask

  task automatic clear_stats();
    first_plot = -1;
    last_plot  = -1;
    max_gap    = 0;
    plot_cnt   = 0;
    busy_len   = 0;
    busy_rise  = -1;
    done_cyc.delete();
  endtask

  // hold=1 keeps Start high throughout; otherwise Start is pulsed and
  // Continuous chains n frames, dropping once the last frame is under way.
  task automatic run_frames(input int n, input bit hold);
    int base, budget;
    push_frames(n);
    base       = done_cnt;
    budget     = n * (FRAME_CYC + 4) + 20;
    Continuous = !hold && (n > 1);
    Start      = 1'b1;
    tick(1);
    if (!hold) Start = 1'b0;
    while (done_cnt < base + n && budget > 0) begin
      if (done_cnt >= base + n - 1 && FrameDone !== 1'b1) Continuous = 1'b0;
      tick(1);
      budget--;
    end
    Start      = 1'b0;
    Continuous = 1'b0;
    check("frames_done", done_cnt - base, n);
  endtask

  initial begin
    int budget;
    Reset = 1'b1; Start = 1'b0; Continuous = 1'b0;
    clear_stats();
    tick(3);
    check("rst_vgax", VGAx, 0);
    check("rst_vgay", VGAy, 0);
    check("rst_plot", Plot, 0);
    check("rst_plotxy", {PlotX, PlotY}, 0);
    check("rst_plotcol", PlotCol, 0);
    check("rst_busy", Busy, 0);
    check("rst_framedone", FrameDone, 0);
    check("rst_framecount", FrameCount, 0);
    Reset = 1'b0;
    tick(2);
    check("idle_busy", Busy, 0);

    // Single frame from a Start pulse.
    clear_stats();
    run_frames(1, 1'b0);
    tick(3);
    check("first_plot_lat", first_plot - busy_rise, TL);
    check("busy_len", busy_len, TW * TH + TL);
    check("plot_cnt", plot_cnt, TW * TH);
    check("fc_one", FrameCount, 1);
    check("q_empty_1", exp_q.size(), 0);
    check("idle_vga", {VGAx, VGAy}, 0);
    check("idle_plot", Plot, 0);

    // Three chained frames.
    clear_stats();
    run_frames(3, 1'b0);
    tick(3);
    check("cont_done_n", done_cyc.size(), 3);
    if (done_cyc.size() == 3) begin
      check("cont_space_1", done_cyc[1] - done_cyc[0], FRAME_CYC);
      check("cont_space_2", done_cyc[2] - done_cyc[1], FRAME_CYC);
    end
    check("cont_gap", max_gap, TL + 1);
    check("cont_plots", plot_cnt, 3 * TW * TH);
    check("fc_four", FrameCount, 4);
    check("q_empty_3", exp_q.size(), 0);

    // Start held high: IDLE is revisited between frames.
    clear_stats();
    run_frames(2, 1'b1);
    tick(5);
    check("hold_done_n", done_cyc.size(), 2);
    if (done_cyc.size() == 2)
      check("hold_space", done_cyc[1] - done_cyc[0], FRAME_CYC + 1);
    check("hold_idle", Busy, 0);
    check("fc_six", FrameCount, 6);
    check("q_empty_h", exp_q.size(), 0);

    // Reset mid-frame at (5,2).
    clear_stats();
    push_frames(1);
    Start = 1'b1;
    tick(1);
    Start = 1'b0;
    budget = 100;
    while (!(VGAx == 9'd5 && VGAy == 8'd2) && budget > 0) begin
      tick(1);
      budget--;
    end
    check("mid_reached", budget > 0, 1);
    Reset = 1'b1;
    tick(1);
    check("mid_plot", Plot, 0);
    check("mid_busy", Busy, 0);
    check("mid_vga", {VGAx, VGAy}, 0);
    check("mid_fc", FrameCount, 0);
    Reset = 1'b0;
    exp_q.delete();
    tick(2);
    check("mid_still_idle", Plot, 0);
    clear_stats();
    run_frames(1, 1'b0);
    tick(3);
    check("restart_lat", first_plot - busy_rise, TL);
    check("restart_fc", FrameCount, 1);
    check("q_empty_r", exp_q.size(), 0);

    // FrameCount wrap.
    run_frames(254, 1'b0);
    tick(3);
    check("fc_255", FrameCount, 255);
    run_frames(1, 1'b0);
    tick(3);
    check("fc_wrap", FrameCount, 0);
    check("q_empty_w", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
